// File: rtl/sc_micro_sequencer.sv
// Microprogram sequencer: selects the next control-store address from the MIR
// COND/JUMP fields, latched PSR and IR, and stalls on memory microinstructions.
module sc_micro_sequencer #(
  parameter int CS_ADDRWIDTH = 11,
  parameter int IR_DATAWIDTH = 32
) (
  input  logic                    SC_MIR_CLOCK_50,
  input  logic                    SC_MIR_RESET_InHigh,
  input  logic                    SC_MICROSEQ_clear_InLow,
  input  logic [2:0]              SC_MICROSEQ_Cond_InBUS,
  input  logic [CS_ADDRWIDTH-1:0] SC_MICROSEQ_JumpAddr_InBUS,
  input  logic                    SC_MICROSEQ_Read_In,
  input  logic                    SC_MICROSEQ_Write_In,
  input  logic [3:0]              SC_MICROSEQ_ALU_InBUS,
  input  logic [3:0]              SC_MICROSEQ_Flags_InBUS,
  input  logic [IR_DATAWIDTH-1:0] SC_MICROSEQ_IR_InBUS,
  input  logic                    SC_MICROSEQ_MemDone_In,
  output logic [CS_ADDRWIDTH-1:0] SC_MICROSEQ_CSAddr_OutBUS,
  output logic                    SC_MICROSEQ_MIRLoad_Out,
  output logic                    SC_MICROSEQ_MemReq_Out,
  output logic [3:0]              SC_MICROSEQ_PSR_OutBUS,
  output logic [CS_ADDRWIDTH-1:0] SC_MICROSEQ_uPC_OutBUS
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CS_ADDRWIDTH-1:0] upc_q;
  logic [3:0]              psr_q;

  logic [CS_ADDRWIDTH-1:0] next_addr;
  logic [CS_ADDRWIDTH-1:0] decode_addr;
  logic [CS_ADDRWIDTH-1:0] target;
  logic                    mem_access;
  logic                    retire;
  logic                    cc_alu;
  logic                    unused_ir;

  assign next_addr   = upc_q + CS_ADDRWIDTH'(1);
  assign decode_addr = {1'b1, SC_MICROSEQ_IR_InBUS[31:30], SC_MICROSEQ_IR_InBUS[24:19], 2'b00};
  assign mem_access  = SC_MICROSEQ_Read_In | SC_MICROSEQ_Write_In;
  assign cc_alu      = (SC_MICROSEQ_ALU_InBUS[3:2] == 2'b00);
  assign unused_ir   = ^SC_MICROSEQ_IR_InBUS;

  // Branch conditions read the latched PSR {n,z,v,c}, never the live flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target = next_addr;
    case (SC_MICROSEQ_Cond_InBUS)
      3'b001: target = psr_q[3] ? SC_MICROSEQ_JumpAddr_InBUS : next_addr;
      3'b010: target = psr_q[2] ? SC_MICROSEQ_JumpAddr_InBUS : next_addr;
      3'b011: target = psr_q[1] ? SC_MICROSEQ_JumpAddr_InBUS : next_addr;
      3'b100: target = psr_q[0] ? SC_MICROSEQ_JumpAddr_InBUS : next_addr;
      3'b101: target = SC_MICROSEQ_IR_InBUS[13] ? SC_MICROSEQ_JumpAddr_InBUS : next_addr;
      3'b110: target = SC_MICROSEQ_JumpAddr_InBUS;
      3'b111: target = decode_addr;
      default: target = next_addr;
    endcase
  end

  always_comb begin
    SC_MICROSEQ_CSAddr_OutBUS = '0;
    SC_MICROSEQ_MIRLoad_Out   = 1'b1;
    SC_MICROSEQ_MemReq_Out    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_access) begin
          SC_MICROSEQ_CSAddr_OutBUS = upc_q;
          SC_MICROSEQ_MIRLoad_Out   = 1'b0;
          SC_MICROSEQ_MemReq_Out    = 1'b1;
        end else begin
          SC_MICROSEQ_CSAddr_OutBUS = target;
        end
      end
      ST_MEM_WAIT: begin
        SC_MICROSEQ_MemReq_Out = 1'b1;
        if (SC_MICROSEQ_MemDone_In) begin
          SC_MICROSEQ_CSAddr_OutBUS = target;
        end else begin
          SC_MICROSEQ_CSAddr_OutBUS = upc_q;
          SC_MICROSEQ_MIRLoad_Out   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign retire = SC_MICROSEQ_MIRLoad_Out && (state_q == ST_RUN || state_q == ST_MEM_WAIT);

  // Clear has priority over every transition except the asynchronous reset.
  always_ff @(posedge SC_MIR_CLOCK_50 or posedge SC_MIR_RESET_InHigh) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (SC_MIR_RESET_InHigh) begin
      state_q <= ST_INIT;
      upc_q   <= '0;
      psr_q   <= '0;
    end else if (!SC_MICROSEQ_clear_InLow) begin
      state_q <= ST_INIT;
      upc_q   <= '0;
      psr_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN:      if (mem_access) state_q <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (SC_MICROSEQ_MemDone_In) state_q <= ST_RUN;
        default: begin
          state_q <= ST_RUN;
          upc_q   <= '0;
        end
      endcase
      if (retire) begin
        upc_q <= target;
        if (cc_alu) psr_q <= SC_MICROSEQ_Flags_InBUS;
      end
    end
  end

  assign SC_MICROSEQ_PSR_OutBUS = psr_q;
  assign SC_MICROSEQ_uPC_OutBUS = upc_q;

endmodule

// File: tb/tb_sc_micro_sequencer.sv
// Self-checking bench for sc_micro_sequencer: directed vector table, hand-written
// corner sequences, then randomized stimulus against a behavioural model.
module tb_sc_micro_sequencer;

  logic        clk;
  logic        rst;
  logic        clr_n;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic        rd, wr;
  logic [3:0]  alu, flags;
  logic [31:0] ir;
  logic        done;
  logic [10:0] cs_addr;
  logic        mir_load, mem_req;
  logic [3:0]  psr;
  logic [10:0] upc;

  int n_tests = 0;
  int n_fail  = 0;

  sc_micro_sequencer dut (
    .SC_MIR_CLOCK_50            (clk),
    .SC_MIR_RESET_InHigh        (rst),
    .SC_MICROSEQ_clear_InLow    (clr_n),
    .SC_MICROSEQ_Cond_InBUS     (cond),
    .SC_MICROSEQ_JumpAddr_InBUS (jump),
    .SC_MICROSEQ_Read_In        (rd),
    .SC_MICROSEQ_Write_In       (wr),
    .SC_MICROSEQ_ALU_InBUS      (alu),
    .SC_MICROSEQ_Flags_InBUS    (flags),
    .SC_MICROSEQ_IR_InBUS       (ir),
    .SC_MICROSEQ_MemDone_In     (done),
    .SC_MICROSEQ_CSAddr_OutBUS  (cs_addr),
    .SC_MICROSEQ_MIRLoad_Out    (mir_load),
    .SC_MICROSEQ_MemReq_Out     (mem_req),
    .SC_MICROSEQ_PSR_OutBUS     (psr),
    .SC_MICROSEQ_uPC_OutBUS     (upc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr_n;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd, wr;
    logic [3:0]  alu, flags;
    logic [31:0] ir;
    logic        done;
    logic [10:0] e_cs;
    logic        e_load, e_req;
    logic [10:0] e_upc;
    logic [3:0]  e_psr;
  } vec_t;

  localparam logic [31:0] IR_DEC = 32'h8140_2000;  // op=10, op3=101000, IR[13]=1

  vec_t vecs[$];

  // Packed view {cs, load, req, upc, psr} so one comparison covers all outputs.
  function automatic logic [31:0] pack(input logic [10:0] c, input logic l, input logic r,
                                       input logic [10:0] u, input logic [3:0] p);
    return {4'h0, c, l, r, u, p};
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(cs_addr, mir_load, mem_req, upc, psr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cs,ld,rq,upc,psr}=%h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cn, input logic [2:0] c, input logic [10:0] j,
                              input logic r, input logic w, input logic [3:0] a,
                              input logic [3:0] f, input logic [31:0] i, input logic d,
                              input logic [10:0] ec, input logic el, input logic er,
                              input logic [10:0] eu, input logic [3:0] ep);
    vec_t v;
    v.clr_n = cn; v.cond = c; v.jump = j; v.rd = r; v.wr = w; v.alu = a; v.flags = f;
    v.ir = i; v.done = d; v.e_cs = ec; v.e_load = el; v.e_req = er; v.e_upc = eu; v.e_psr = ep;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    clr_n = v.clr_n; cond = v.cond; jump = v.jump; rd = v.rd; wr = v.wr;
    alu = v.alu; flags = v.flags; ir = v.ir; done = v.done;
  endtask

  // Entered at a falling edge: drive, sample mid-low-phase, then wait for the next falling edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #2;
    check(name, dut_pack(), pack(v.e_cs, v.e_load, v.e_req, v.e_upc, v.e_psr));
    @(negedge clk);
  endtask

  // Behavioural reference: tracks which microinstruction the MIR holds and whether it waits on memory.
  bit m_started, m_waiting;
  int m_upc, m_psr;

  function automatic int m_target();
    int nxt;
    int taken;
    nxt = (m_upc + 1) % 2048;
    case (int'(cond))
      0: taken = 0;
      1: taken = (m_psr >> 3) & 1;
      2: taken = (m_psr >> 2) & 1;
      3: taken = (m_psr >> 1) & 1;
      4: taken = m_psr & 1;
      5: taken = int'(ir[13]);
      6: taken = 1;
      default: return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
    endcase
    return (taken != 0) ? int'(jump) : nxt;
  endfunction

  initial begin
    vec_t v;
    int   e_cs;
    bit   e_load, e_req;

    rst = 1'b1; clr_n = 1'b1; cond = '0; jump = '0; rd = 1'b0; wr = 1'b0;
    alu = 4'hF; flags = '0; ir = '0; done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", dut_pack(), pack(11'h000, 1'b1, 1'b0, 11'h000, 4'h0));
    rst = 1'b0;

    // cl cond  jump    rd wr alu   flg   ir      dn  | cs      ld rq upc     psr
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h000, 1, 0, 11'h000, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h001, 1, 0, 11'h000, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h002, 1, 0, 11'h001, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h003, 1, 0, 11'h002, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'h3, 4'h9, 32'h0,  0, 11'h004, 1, 0, 11'h003, 4'h0));
    vecs.push_back(mk(1, 3'd1, 11'h050, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h050, 1, 0, 11'h004, 4'h9));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'h5, 4'h6, 32'h0,  0, 11'h051, 1, 0, 11'h050, 4'h9));
    vecs.push_back(mk(1, 3'd2, 11'h123, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h052, 1, 0, 11'h051, 4'h9));
    vecs.push_back(mk(1, 3'd1, 11'h300, 0, 0, 4'h0, 4'h4, 32'h0,  0, 11'h300, 1, 0, 11'h052, 4'h9));
    vecs.push_back(mk(1, 3'd2, 11'h123, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h123, 1, 0, 11'h300, 4'h4));
    vecs.push_back(mk(1, 3'd1, 11'h7FF, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h124, 1, 0, 11'h123, 4'h4));
    vecs.push_back(mk(1, 3'd3, 11'h200, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h125, 1, 0, 11'h124, 4'h4));
    vecs.push_back(mk(1, 3'd4, 11'h200, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h126, 1, 0, 11'h125, 4'h4));
    vecs.push_back(mk(1, 3'd6, 11'h7FF, 0, 0, 4'h1, 4'h3, 32'h0,  0, 11'h7FF, 1, 0, 11'h126, 4'h4));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h000, 1, 0, 11'h7FF, 4'h3));
    vecs.push_back(mk(1, 3'd3, 11'h040, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h040, 1, 0, 11'h000, 4'h3));
    vecs.push_back(mk(1, 3'd4, 11'h080, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h080, 1, 0, 11'h040, 4'h3));
    vecs.push_back(mk(1, 3'd7, 11'h000, 0, 0, 4'hF, 4'h0, IR_DEC, 0, 11'h6A0, 1, 0, 11'h080, 4'h3));
    vecs.push_back(mk(1, 3'd5, 11'h010, 0, 0, 4'hF, 4'h0, IR_DEC, 0, 11'h010, 1, 0, 11'h6A0, 4'h3));
    vecs.push_back(mk(1, 3'd5, 11'h020, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h011, 1, 0, 11'h010, 4'h3));
    // Read access: MemDone ignored in RUN, three idle wait cycles, then completion.
    vecs.push_back(mk(1, 3'd6, 11'h400, 1, 0, 4'h2, 4'hC, 32'h0,  1, 11'h011, 0, 1, 11'h011, 4'h3));
    vecs.push_back(mk(1, 3'd6, 11'h400, 1, 0, 4'h2, 4'hC, 32'h0,  0, 11'h011, 0, 1, 11'h011, 4'h3));
    vecs.push_back(mk(1, 3'd6, 11'h400, 1, 0, 4'h2, 4'hC, 32'h0,  0, 11'h011, 0, 1, 11'h011, 4'h3));
    vecs.push_back(mk(1, 3'd6, 11'h400, 1, 0, 4'h2, 4'hC, 32'h0,  0, 11'h011, 0, 1, 11'h011, 4'h3));
    vecs.push_back(mk(1, 3'd6, 11'h400, 1, 0, 4'h2, 4'hC, 32'h0,  1, 11'h400, 1, 1, 11'h011, 4'h3));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h401, 1, 0, 11'h400, 4'hC));
    // RD and WR together, minimum two-cycle access.
    vecs.push_back(mk(1, 3'd0, 11'h000, 1, 1, 4'hF, 4'h0, 32'h0,  0, 11'h401, 0, 1, 11'h401, 4'hC));
    vecs.push_back(mk(1, 3'd0, 11'h000, 1, 1, 4'hF, 4'h0, 32'h0,  1, 11'h402, 1, 1, 11'h401, 4'hC));
    // Clear in RUN, then clear in MEM_WAIT.
    vecs.push_back(mk(0, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h403, 1, 0, 11'h402, 4'hC));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h000, 1, 0, 11'h000, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h001, 1, 0, 11'h000, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 1, 4'hF, 4'h0, 32'h0,  0, 11'h001, 0, 1, 11'h001, 4'h0));
    vecs.push_back(mk(0, 3'd0, 11'h000, 0, 1, 4'hF, 4'h0, 32'h0,  0, 11'h001, 0, 1, 11'h001, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h000, 1, 0, 11'h000, 4'h0));
    vecs.push_back(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0,  0, 11'h001, 1, 0, 11'h000, 4'h0));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Clear while uPC=0x2A0 and PSR=1111.
    step(mk(1, 3'd6, 11'h2A0, 0, 0, 4'h3, 4'hF, 32'h0, 0, 11'h2A0, 1, 0, 11'h001, 4'h0), "clr_setup");
    step(mk(0, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0, 0, 11'h2A1, 1, 0, 11'h2A0, 4'hF), "clr_edge");
    step(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0, 0, 11'h000, 1, 0, 11'h000, 4'h0), "clr_after");
    step(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0, 0, 11'h001, 1, 0, 11'h000, 4'h0), "clr_next");

    // Asynchronous reset during MEM_WAIT, then a late MemDone in RUN.
    step(mk(1, 3'd0, 11'h000, 1, 0, 4'hF, 4'h0, 32'h0, 0, 11'h001, 0, 1, 11'h001, 4'h0), "rst_rd");
    drive(mk(1, 3'd0, 11'h000, 1, 0, 4'hF, 4'h0, 32'h0, 0, 11'h0, 0, 0, 11'h0, 4'h0));
    #2;
    check("rst_wait", dut_pack(), pack(11'h001, 1'b0, 1'b1, 11'h001, 4'h0));
    rst = 1'b1;
    #1;
    check("rst_async", dut_pack(), pack(11'h000, 1'b1, 1'b0, 11'h000, 4'h0));
    @(negedge clk);
    rst = 1'b0;
    step(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0, 1, 11'h000, 1, 0, 11'h000, 4'h0), "rst_init");
    step(mk(1, 3'd0, 11'h000, 0, 0, 4'hF, 4'h0, 32'h0, 1, 11'h001, 1, 0, 11'h000, 4'h0), "rst_late_done");

    // Randomized run against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_started = 0; m_waiting = 0; m_upc = 0; m_psr = 0;
    for (int n = 0; n < 3000; n++) begin
      int tgt;
      clr_n = ($urandom_range(0, 40) != 0);
      cond  = 3'($urandom_range(0, 7));
      jump  = 11'($urandom);
      rd    = ($urandom_range(0, 4) == 0);
      wr    = ($urandom_range(0, 5) == 0);
      alu   = 4'($urandom);
      flags = 4'($urandom);
      ir    = $urandom;
      done  = ($urandom_range(0, 2) == 0);
      tgt   = m_target();
      if (!m_started) begin
        e_cs = 0; e_load = 1; e_req = 0;
      end else if (m_waiting) begin
        e_req = 1; e_load = done; e_cs = done ? tgt : m_upc;
      end else if (rd || wr) begin
        e_cs = m_upc; e_load = 0; e_req = 1;
      end else begin
        e_cs = tgt; e_load = 1; e_req = 0;
      end
      #2;
      check($sformatf("rand%0d", n), dut_pack(),
            pack(11'(e_cs), e_load, e_req, 11'(m_upc), 4'(m_psr)));
      if (!clr_n) begin
        m_started = 0; m_waiting = 0; m_upc = 0; m_psr = 0;
      end else if (!m_started) begin
        m_started = 1; m_upc = 0;
      end else if (e_load) begin
        m_upc = tgt; m_waiting = 0;
        if (alu < 4) m_psr = int'(flags);
      end else begin
        m_waiting = 1;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
